// File: rtl/imsic_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imsic_csr_arbiter
// Description : Merges per-hart CSR requests onto the shared IMSIC CSR bus.
//               Round-robin arbitration with one access in flight
//               (IDLE -> ISSUE -> RESP). Illegal priv/vgein combinations are
//               rejected locally and never reach the IMSIC. Read data and the
//               error flag are returned to the winning hart on a valid/ready
//               response channel.
// Ports       : i_clk/ni_rst       clock, asynchronous active-low reset
//               i_req_* / o_req_ready   per-hart request channel
//               o_rsp_* / i_rsp_ready   per-hart response channel
//               o_select_imsic, o_priv_lvl, o_vgein, o_imsic_addr,
//               o_imsic_data, o_imsic_we, o_imsic_claim   shared IMSIC bus
//               i_imsic_rdata, i_imsic_exception          IMSIC return path
// Revision    : 1.0 - initial release
// ============================================================================
module imsic_csr_arbiter #(
    parameter int NR_IMSICS             = 4,
    parameter int NR_VS_FILES_PER_IMSIC = 1,
    parameter int VS_INTP_FILE_LEN      = $clog2(NR_VS_FILES_PER_IMSIC)
) (
    input  logic                                     i_clk,
    input  logic                                     ni_rst,
    input  logic [NR_IMSICS-1:0]                     i_req_valid,
    output logic [NR_IMSICS-1:0]                     o_req_ready,
    input  logic [NR_IMSICS-1:0][1:0]                i_req_priv_lvl,
    input  logic [NR_IMSICS-1:0][VS_INTP_FILE_LEN:0] i_req_vgein,
    input  logic [NR_IMSICS-1:0][31:0]               i_req_addr,
    input  logic [NR_IMSICS-1:0][31:0]               i_req_data,
    input  logic [NR_IMSICS-1:0]                     i_req_we,
    input  logic [NR_IMSICS-1:0]                     i_req_claim,
    output logic [NR_IMSICS-1:0]                     o_rsp_valid,
    input  logic [NR_IMSICS-1:0]                     i_rsp_ready,
    output logic [31:0]                              o_rsp_data,
    output logic                                     o_rsp_error,
    output logic [NR_IMSICS-1:0]                     o_select_imsic,
    output logic [1:0]                               o_priv_lvl,
    output logic [VS_INTP_FILE_LEN:0]                o_vgein,
    output logic [31:0]                              o_imsic_addr,
    output logic [31:0]                              o_imsic_data,
    output logic                                     o_imsic_we,
    output logic                                     o_imsic_claim,
    input  logic [NR_IMSICS-1:0][31:0]               i_imsic_rdata,
    input  logic [NR_IMSICS-1:0]                     i_imsic_exception
);

    localparam int c_PTR_W = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1;
    localparam int c_VG_W  = VS_INTP_FILE_LEN + 1;
    localparam logic [c_VG_W-1:0]    c_VS_MAX  = c_VG_W'(NR_VS_FILES_PER_IMSIC);
    localparam logic [c_PTR_W-1:0]   c_LAST    = c_PTR_W'(NR_IMSICS - 1);
    localparam logic [NR_IMSICS-1:0] c_ONE     = NR_IMSICS'(1);
    localparam logic [1:0]           c_PRIV_VS = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                 r_state_q,    w_state_d;
    logic [c_PTR_W-1:0]     r_ptr_q,      w_ptr_d;
    logic [c_PTR_W-1:0]     r_winner_q,   w_winner_d;
    logic                   r_we_lat_q,   w_we_lat_d;
    logic                   r_illegal_q,  w_illegal_d;
    logic [NR_IMSICS-1:0]   r_select_q,   w_select_d;
    logic [1:0]             r_priv_q,     w_priv_d;
    logic [c_VG_W-1:0]      r_vgein_q,    w_vgein_d;
    logic [31:0]            r_addr_q,     w_addr_d;
    logic [31:0]            r_data_q,     w_data_d;
    logic                   r_we_q,       w_we_d;
    logic                   r_claim_q,    w_claim_d;
    logic [NR_IMSICS-1:0]   r_rsp_valid_q, w_rsp_valid_d;
    logic [31:0]            r_rsp_data_q,  w_rsp_data_d;
    logic                   r_rsp_error_q, w_rsp_error_d;

    logic                   w_found;
    logic [c_PTR_W-1:0]     w_win;
    logic [c_PTR_W-1:0]     w_cand;
    logic                   w_illegal;
    logic [NR_IMSICS-1:0]   w_grant;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NR_IMSICS; i++) begin
            w_cand = c_PTR_W'((int'(r_ptr_q) + i) % NR_IMSICS);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Priv 00 is reserved; a VS access needs a guest index in 1..NR_VS.
    always_comb begin
        w_illegal = (i_req_priv_lvl[w_win] == 2'b00) ||
                    ((i_req_priv_lvl[w_win] == c_PRIV_VS) &&
                     ((i_req_vgein[w_win] == '0) || (i_req_vgein[w_win] > c_VS_MAX)));
    end

    assign w_grant = (r_state_q == S_IDLE && w_found) ? (c_ONE << w_win) : '0;

    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_winner_d    = r_winner_q;
        w_we_lat_d    = r_we_lat_q;
        w_illegal_d   = r_illegal_q;
        // Bus fields default to zero so they are only live for the ISSUE cycle.
        w_select_d    = '0;
        w_priv_d      = '0;
        w_vgein_d     = '0;
        w_addr_d      = '0;
        w_data_d      = '0;
        w_we_d        = 1'b0;
        w_claim_d     = 1'b0;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_data_d  = r_rsp_data_q;
        w_rsp_error_d = r_rsp_error_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_found) begin
                    w_state_d   = S_ISSUE;
                    w_winner_d  = w_win;
                    w_we_lat_d  = i_req_we[w_win];
                    w_illegal_d = w_illegal;
                    if (!w_illegal) begin
                        w_select_d = c_ONE << w_win;
                        w_priv_d   = i_req_priv_lvl[w_win];
                        w_vgein_d  = i_req_vgein[w_win];
                        w_addr_d   = i_req_addr[w_win];
                        w_data_d   = i_req_data[w_win];
                        w_we_d     = i_req_we[w_win];
                        w_claim_d  = i_req_claim[w_win];
                    end
                end
            end
            S_ISSUE: begin
                w_state_d     = S_RESP;
                w_rsp_valid_d = c_ONE << r_winner_q;
                if (r_illegal_q) begin
                    w_rsp_error_d = 1'b1;
                    w_rsp_data_d  = '0;
                end else begin
                    w_rsp_error_d = i_imsic_exception[r_winner_q];
                    w_rsp_data_d  = r_we_lat_q ? 32'h0 : i_imsic_rdata[r_winner_q];
                end
            end
            S_RESP: begin
                if (i_rsp_ready[r_winner_q]) begin
                    w_state_d     = S_IDLE;
                    w_rsp_valid_d = '0;
                    w_rsp_data_d  = '0;
                    w_rsp_error_d = 1'b0;
                    w_ptr_d       = (r_winner_q == c_LAST) ? '0 : r_winner_q + 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_state_q     <= S_IDLE;
            r_ptr_q       <= '0;
            r_winner_q    <= '0;
            r_we_lat_q    <= 1'b0;
            r_illegal_q   <= 1'b0;
            r_select_q    <= '0;
            r_priv_q      <= '0;
            r_vgein_q     <= '0;
            r_addr_q      <= '0;
            r_data_q      <= '0;
            r_we_q        <= 1'b0;
            r_claim_q     <= 1'b0;
            r_rsp_valid_q <= '0;
            r_rsp_data_q  <= '0;
            r_rsp_error_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_winner_q    <= w_winner_d;
            r_we_lat_q    <= w_we_lat_d;
            r_illegal_q   <= w_illegal_d;
            r_select_q    <= w_select_d;
            r_priv_q      <= w_priv_d;
            r_vgein_q     <= w_vgein_d;
            r_addr_q      <= w_addr_d;
            r_data_q      <= w_data_d;
            r_we_q        <= w_we_d;
            r_claim_q     <= w_claim_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_data_q  <= w_rsp_data_d;
            r_rsp_error_q <= w_rsp_error_d;
        end
    end

    // Ready is the only combinational output; mask it so reset forces it low too.
    assign o_req_ready    = w_grant & {NR_IMSICS{ni_rst}};
    assign o_rsp_valid    = r_rsp_valid_q;
    assign o_rsp_data     = r_rsp_data_q;
    assign o_rsp_error    = r_rsp_error_q;
    assign o_select_imsic = r_select_q;
    assign o_priv_lvl     = r_priv_q;
    assign o_vgein        = r_vgein_q;
    assign o_imsic_addr   = r_addr_q;
    assign o_imsic_data   = r_data_q;
    assign o_imsic_we     = r_we_q;
    assign o_imsic_claim  = r_claim_q;

endmodule
`default_nettype wire

// File: tb/tb_imsic_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imsic_csr_arbiter
// Description : Self-checking bench for imsic_csr_arbiter (4 harts, 1 guest
//               file). Directed scenarios plus a randomized run compared
//               against a transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imsic_csr_arbiter;

    localparam int N   = 4;
    localparam int NVS = 1;
    localparam int VGW = 1;

    logic                  clk;
    logic                  ni_rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][1:0]     req_priv;
    logic [N-1:0][VGW-1:0] req_vgein;
    logic [N-1:0][31:0]    req_addr;
    logic [N-1:0][31:0]    req_data;
    logic [N-1:0]          req_we;
    logic [N-1:0]          req_claim;
    logic [N-1:0]          rsp_valid;
    logic [N-1:0]          rsp_ready;
    logic [31:0]           rsp_data;
    logic                  rsp_error;
    logic [N-1:0]          sel;
    logic [1:0]            priv_o;
    logic [VGW-1:0]        vgein_o;
    logic [31:0]           addr_o;
    logic [31:0]           data_o;
    logic                  we_o;
    logic                  claim_o;
    logic [N-1:0][31:0]    imsic_rdata;
    logic [N-1:0]          imsic_exc;

    logic [72:0]  bus_vec;
    logic [113:0] all_out;

    int n_tests = 0;
    int n_fail  = 0;

    imsic_csr_arbiter #(
        .NR_IMSICS             (N),
        .NR_VS_FILES_PER_IMSIC (NVS)
    ) dut (
        .i_clk             (clk),
        .ni_rst            (ni_rst),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_priv_lvl    (req_priv),
        .i_req_vgein       (req_vgein),
        .i_req_addr        (req_addr),
        .i_req_data        (req_data),
        .i_req_we          (req_we),
        .i_req_claim       (req_claim),
        .o_rsp_valid       (rsp_valid),
        .i_rsp_ready       (rsp_ready),
        .o_rsp_data        (rsp_data),
        .o_rsp_error       (rsp_error),
        .o_select_imsic    (sel),
        .o_priv_lvl        (priv_o),
        .o_vgein           (vgein_o),
        .o_imsic_addr      (addr_o),
        .o_imsic_data      (data_o),
        .o_imsic_we        (we_o),
        .o_imsic_claim     (claim_o),
        .i_imsic_rdata     (imsic_rdata),
        .i_imsic_exception (imsic_exc)
    );

    assign bus_vec = {sel, priv_o, vgein_o, addr_o, data_o, we_o, claim_o};
    assign all_out = {req_ready, rsp_valid, rsp_data, rsp_error, bus_vec};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference rules ----------------
    function automatic logic is_legal(input logic [1:0] p, input int vg);
        if (p == 2'b00) return 1'b0;
        if (p == 2'b10 && (vg < 1 || vg > NVS)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_winner(input int ptr, input logic [N-1:0] pend);
        for (int k = 0; k < N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [72:0] exp_bus(input int h, input logic [1:0] p, input logic [VGW-1:0] vg,
                                            input logic [31:0] a, input logic [31:0] d,
                                            input logic we, input logic cl);
        logic [N-1:0] s;
        s = '0;
        s[h] = 1'b1;
        return {s, p, vg, a, d, we, cl};
    endfunction

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        req_valid = '0; req_priv = '0; req_vgein = '0; req_addr = '0; req_data = '0;
        req_we = '0; req_claim = '0; rsp_ready = '0; imsic_exc = '0;
    endtask

    task automatic apply_reset();
        ni_rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 ni_rst = 1'b1;
    endtask

    // One access on an idle arbiter; returns what was seen on each phase.
    task automatic single_access(input int h, input logic [1:0] p, input logic [VGW-1:0] vg,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic we, input logic cl,
                                 output logic [N-1:0] rdy, output logic [72:0] bus,
                                 output logic [N-1:0] rv, output logic [31:0] rd,
                                 output logic re, output int clm);
        req_valid = '0;
        req_valid[h] = 1'b1;
        req_priv[h] = p; req_vgein[h] = vg; req_addr[h] = a; req_data[h] = d;
        req_we[h] = we; req_claim[h] = cl;
        rsp_ready = '0;
        clm = 0;
        @(negedge clk); rdy = req_ready; clm += int'(claim_o);
        @(posedge clk); #1 req_valid[h] = 1'b0;
        @(negedge clk); bus = bus_vec; clm += int'(claim_o);
        @(posedge clk); #1;
        @(negedge clk); rv = rsp_valid; rd = rsp_data; re = rsp_error; clm += int'(claim_o);
        rsp_ready[h] = 1'b1;
        @(posedge clk); #1 rsp_ready = '0;
        @(negedge clk); clm += int'(claim_o);
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ni_rst = 1'b0;
        clear_inputs();
        req_valid = 4'b1011;
        @(negedge clk);
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(posedge clk); #1 req_valid = '0; ni_rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h want 0", all_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_read();
        logic [N-1:0] rdy, rv; logic [72:0] bus; logic [31:0] rd; logic re; int clm;
        apply_reset();
        imsic_rdata[0] = 32'h0000_CAFE;
        single_access(0, 2'b11, 1'b0, 32'h70, 32'h0, 1'b0, 1'b0, rdy, bus, rv, rd, re, clm);
        n_tests++;
        if (rdy !== 4'b0001) begin n_fail++; $display("FAIL basic_ready: got %b want 0001", rdy); end
        n_tests++;
        if (bus !== exp_bus(0, 2'b11, 1'b0, 32'h70, 32'h0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL basic_bus: got %h want %h", bus, exp_bus(0, 2'b11, 1'b0, 32'h70, 32'h0, 1'b0, 1'b0));
        end
        n_tests++;
        if (rv !== 4'b0001 || rd !== 32'hCAFE || re !== 1'b0) begin
            n_fail++; $display("FAIL basic_rsp: got v=%b d=%h e=%b want v=0001 d=0000cafe e=0", rv, rd, re);
        end
        n_tests++;
        if (rsp_valid !== '0 || rsp_data !== '0) begin
            n_fail++; $display("FAIL basic_rsp_cleared: got v=%b d=%h want 0", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_round_robin();
        int seq [4] = '{0, 2, 3, 0};
        logic [N-1:0] exp;
        apply_reset();
        rsp_ready = '1;
        for (int h = 0; h < N; h++) begin
            req_priv[h] = 2'b11; req_addr[h] = 32'h70 + h; req_we[h] = 1'b0;
        end
        req_valid = 4'b1101;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp = '0;
            if (k % 3 == 0) exp[seq[k / 3]] = 1'b1;
            n_tests++;
            if (req_ready !== exp) begin
                n_fail++; $display("FAIL rr_grant cycle %0d: got %b want %b", k, req_ready, exp);
            end
        end
        @(posedge clk); #1 req_valid = '0; rsp_ready = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        logic [N-1:0] rdy, rv; logic [72:0] bus; logic [31:0] rd; logic re; int clm;
        logic [1:0] privs [3] = '{2'b10, 2'b00, 2'b10};
        logic [VGW-1:0] vgs [3] = '{1'b0, 1'b1, 1'b1};
        apply_reset();
        imsic_rdata[1] = 32'h1234_5678;
        for (int t = 0; t < 3; t++) begin
            single_access(1, privs[t], vgs[t], 32'h40, 32'hA5A5_0000 + t, t != 2, 1'b0,
                          rdy, bus, rv, rd, re, clm);
            n_tests++;
            if (t < 2) begin
                if (bus !== '0 || rv !== 4'b0010 || re !== 1'b1 || rd !== '0) begin
                    n_fail++;
                    $display("FAIL illegal_%0d: got bus=%h v=%b e=%b d=%h want bus=0 v=0010 e=1 d=0", t, bus, rv, re, rd);
                end
            end else begin
                if (bus !== exp_bus(1, 2'b10, 1'b1, 32'h40, 32'hA5A5_0002, 1'b0, 1'b0) ||
                    rv !== 4'b0010 || re !== 1'b0 || rd !== 32'h1234_5678) begin
                    n_fail++;
                    $display("FAIL legal_vs: got bus=%h v=%b e=%b d=%h want d=12345678 e=0", bus, rv, re, rd);
                end
            end
        end
    endtask

    task automatic test_claim();
        logic [N-1:0] rdy, rv; logic [72:0] bus; logic [31:0] rd; logic re; int clm;
        apply_reset();
        imsic_rdata[2] = 32'h0000_0021;
        single_access(2, 2'b01, 1'b0, 32'h70, 32'h0, 1'b0, 1'b1, rdy, bus, rv, rd, re, clm);
        n_tests++;
        if (clm != 1) begin n_fail++; $display("FAIL claim_cycles: got %0d want 1", clm); end
        n_tests++;
        if (bus[72:69] !== 4'b0100 || bus[0] !== 1'b1) begin
            n_fail++; $display("FAIL claim_select: got sel=%b claim=%b want 0100 1", bus[72:69], bus[0]);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        imsic_exc[1] = 1'b1;
        rsp_ready = 4'b0001;
        req_valid[1] = 1'b1; req_priv[1] = 2'b11; req_we[1] = 1'b1;
        req_addr[1] = 32'h14; req_data[1] = 32'h55;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_valid[0] = 1'b1; req_priv[0] = 2'b11; req_we[0] = 1'b0; req_addr[0] = 32'h70;
        @(negedge clk);
        n_tests++;
        if (req_ready !== '0 || sel !== 4'b0010) begin
            n_fail++; $display("FAIL bp_issue: got rdy=%b sel=%b want 0000 0010", req_ready, sel);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 4'b0010 || rsp_error !== 1'b1 || rsp_data !== '0 || req_ready !== '0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got v=%b e=%b d=%h rdy=%b want 0010 1 0 0000", c, rsp_valid, rsp_error, rsp_data, req_ready);
            end
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1 rsp_ready = '0; imsic_exc = '0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0001 || rsp_valid !== '0) begin
            n_fail++; $display("FAIL bp_release: got rdy=%b v=%b want 0001 0000", req_ready, rsp_valid);
        end
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 rsp_ready = '1;
        @(posedge clk); #1 rsp_ready = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] exp_sel;
        logic [31:0]  exp_d;
        logic         exp_e, legal;
        int ptr, w, stall;
        apply_reset();
        ptr = 0;
        pend = '0;
        for (int t = 0; t < 60; t++) begin
            for (int h = 0; h < N; h++) begin
                if (!pend[h] && ($urandom_range(1, 0) == 1)) begin
                    pend[h] = 1'b1;
                    req_priv[h]  = 2'($urandom_range(3, 0));
                    req_vgein[h] = VGW'($urandom_range(1, 0));
                    req_addr[h]  = $urandom;
                    req_data[h]  = $urandom;
                    req_we[h]    = 1'($urandom_range(1, 0));
                    req_claim[h] = 1'($urandom_range(1, 0));
                end
                imsic_rdata[h] = $urandom;
            end
            if (pend == '0) begin
                pend[0] = 1'b1; req_priv[0] = 2'b11; req_we[0] = 1'b0; req_claim[0] = 1'b0;
            end
            req_valid = pend;
            w = next_winner(ptr, pend);
            exp_sel = '0;
            exp_sel[w] = 1'b1;
            legal = is_legal(req_priv[w], int'(req_vgein[w]));
            @(negedge clk);
            n_tests++;
            if (req_ready !== exp_sel) begin
                n_fail++; $display("FAIL rand_grant t=%0d: got %b want %b", t, req_ready, exp_sel);
            end
            @(posedge clk); #1;
            req_valid[w] = 1'b0;
            pend[w] = 1'b0;
            @(negedge clk);
            n_tests++;
            if (legal) begin
                if (bus_vec !== exp_bus(w, req_priv[w], req_vgein[w], req_addr[w], req_data[w], req_we[w], req_claim[w])) begin
                    n_fail++; $display("FAIL rand_bus t=%0d: got %h want %h", t, bus_vec,
                                       exp_bus(w, req_priv[w], req_vgein[w], req_addr[w], req_data[w], req_we[w], req_claim[w]));
                end
            end else if (bus_vec !== '0) begin
                n_fail++; $display("FAIL rand_bus_blocked t=%0d: got %h want 0", t, bus_vec);
            end
            exp_d = (legal && !req_we[w]) ? imsic_rdata[w] : 32'h0;
            exp_e = !legal;
            stall = $urandom_range(3, 0);
            rsp_ready = 4'($urandom);
            rsp_ready[w] = 1'b0;
            @(posedge clk); #1;
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                n_tests++;
                if (rsp_valid !== exp_sel || rsp_data !== exp_d || rsp_error !== exp_e || req_ready !== '0) begin
                    n_fail++;
                    $display("FAIL rand_rsp t=%0d s=%0d: got v=%b d=%h e=%b rdy=%b want v=%b d=%h e=%b rdy=0",
                             t, s, rsp_valid, rsp_data, rsp_error, req_ready, exp_sel, exp_d, exp_e);
                end
                if (s == stall) rsp_ready[w] = 1'b1;
            end
            @(posedge clk); #1;
            rsp_ready = '0;
            ptr = (w + 1) % N;
        end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_issue();
        apply_reset();
        req_valid[3] = 1'b1; req_priv[3] = 2'b11; req_we[3] = 1'b1; req_claim[3] = 1'b1;
        req_addr[3] = 32'h70; req_data[3] = 32'h9;
        @(posedge clk); #1 req_valid = '0;
        #2;
        n_tests++;
        if (sel !== 4'b1000) begin n_fail++; $display("FAIL mid_issue_sel: got %b want 1000", sel); end
        ni_rst = 1'b0;
        #1;
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", all_out); end
        rsp_ready = '1;
        @(posedge clk); #1 ni_rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (all_out !== '0) begin
                n_fail++; $display("FAIL post_abort cycle %0d: got %h want 0", c, all_out);
            end
        end
        rsp_ready = '0;
    endtask

    initial begin
        ni_rst = 1'b0;
        clear_inputs();
        imsic_rdata = '0;
        test_reset();
        test_basic_read();
        test_round_robin();
        test_illegal();
        test_claim();
        test_backpressure();
        test_random();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
